// File: rtl/alu_rpn_ctrl.sv
// Reverse-Polish style controller for an external ALU.
// The operator keys in operand A, operand B and an opcode with the enter button; the block
// presents them to the ALU, captures the ALU result and flags for one cycle in EXEC, then shows
// the result. Enter in SHOW chains the result into A; undo steps back one entry.
//
// Ports:
//   clk         rising-edge clock
//   resetN      synchronous active-low reset
//   data_in     operand value from switches
//   op_in       operation select (00 add, 01 sub, 10 NAND, 11 NOR)
//   enter/undo  debounced button levels; only rising edges act
//   alu_result  result from the attached ALU
//   alu_flags   flags from the attached ALU, {V,C,Z,N,P,S}
//   A/B/OpCode  registered ALU operands and opcode
//   display     value for the 7-segment driver
//   flags_out   captured ALU flags
//   state_code  current state encoding
//   done        high while a result is shown
module alu_rpn_ctrl #(
  parameter int unsigned M = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [M-1:0] data_in,
  input  logic [1:0]   op_in,
  input  logic         enter,
  input  logic         undo,
  input  logic [M-1:0] alu_result,
  input  logic [5:0]   alu_flags,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [1:0]   OpCode,
  output logic [M-1:0] display,
  output logic [5:0]   flags_out,
  output logic [2:0]   state_code,
  output logic         done
);

  typedef enum logic [2:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  state_e       r_state,  w_state_d;
  logic         r_enter_q, r_undo_q;
  logic         w_enter_ev, w_undo_ev;
  logic [M-1:0] r_a, w_a_d;
  logic [M-1:0] r_b, w_b_d;
  logic [M-1:0] r_result, w_result_d;
  logic [1:0]   r_opcode, w_opcode_d;
  logic [5:0]   r_flags, w_flags_d;

  assign w_enter_ev = enter & ~r_enter_q;
  assign w_undo_ev  = undo  & ~r_undo_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state   <= StWaitA;
      // Held high so a button already pressed through reset yields no event.
      r_enter_q <= 1'b1;
      r_undo_q  <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_opcode  <= 2'b00;
      r_result  <= '0;
      r_flags   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_enter_q <= enter;
      r_undo_q  <= undo;
      r_a       <= w_a_d;
      r_b       <= w_b_d;
      r_opcode  <= w_opcode_d;
      r_result  <= w_result_d;
      r_flags   <= w_flags_d;
    end
  end

  // Enter is tested before undo in every state, so a simultaneous undo is dropped.
  always_comb begin
    w_state_d  = r_state;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_opcode_d = r_opcode;
    w_result_d = r_result;
    w_flags_d  = r_flags;
    case (r_state)
      StWaitA: begin
        if (w_enter_ev) begin
          w_a_d     = data_in;
          w_state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (w_enter_ev) begin
          w_b_d     = data_in;
          w_state_d = StWaitOp;
        end else if (w_undo_ev) begin
          w_state_d = StWaitA;
        end
      end
      StWaitOp: begin
        if (w_enter_ev) begin
          w_opcode_d = op_in;
          w_state_d  = StExec;
        end else if (w_undo_ev) begin
          w_state_d = StWaitB;
        end
      end
      StExec: begin
        w_result_d = alu_result;
        w_flags_d  = alu_flags;
        w_state_d  = StShow;
      end
      StShow: begin
        if (w_enter_ev) begin
          w_a_d     = r_result;
          w_state_d = StWaitB;
        end else if (w_undo_ev) begin
          w_state_d = StWaitA;
        end
      end
      default: w_state_d = StWaitA;
    endcase
  end

  always_comb begin
    display = data_in;
    case (r_state)
      StWaitOp:       display = {{(M-2){1'b0}}, op_in};
      StExec, StShow: display = r_result;
      default:        display = data_in;
    endcase
  end

  assign A          = r_a;
  assign B          = r_b;
  assign OpCode     = r_opcode;
  assign flags_out  = r_flags;
  assign state_code = r_state;
  assign done       = (r_state == StShow);

endmodule

// File: tb/tb_alu_rpn_ctrl.sv
// Directed bench for alu_rpn_ctrl with M=8. A behavioural ALU supplies alu_result from the
// registered operands; alu_flags is driven from tb_flags, set per test to the reference value.
module tb_alu_rpn_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] data_in;
  logic [1:0] op_in;
  logic       enter;
  logic       undo;
  logic [7:0] alu_result;
  logic [5:0] alu_flags;
  logic [7:0] A;
  logic [7:0] B;
  logic [1:0] OpCode;
  logic [7:0] display;
  logic [5:0] flags_out;
  logic [2:0] state_code;
  logic       done;

  logic [5:0] tb_flags;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rpn_ctrl #(.M(8)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .data_in    (data_in),
    .op_in      (op_in),
    .enter      (enter),
    .undo       (undo),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .A          (A),
    .B          (B),
    .OpCode     (OpCode),
    .display    (display),
    .flags_out  (flags_out),
    .state_code (state_code),
    .done       (done)
  );

  always_comb begin
    case (OpCode)
      2'b00:   alu_result = A + B;
      2'b01:   alu_result = A - B;
      2'b10:   alu_result = ~(A & B);
      default: alu_result = ~(A | B);
    endcase
    alu_flags = tb_flags;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse followed by one low cycle so the next press is a fresh edge.
  task automatic press(input bit e, input bit u);
    enter = e;
    undo  = u;
    tick();
    enter = 1'b0;
    undo  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; enter = 1'b0; undo = 1'b0; data_in = 8'h3C; op_in = 2'b00;
    tb_flags = 6'b111111;
    tick();
    checks++; if (state_code !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_code); end
    checks++; if (A !== 8'h00 || B !== 8'h00) begin errors++; $display("FAIL reset_ab got %h/%h want 00/00", A, B); end
    checks++; if (OpCode !== 2'b00) begin errors++; $display("FAIL reset_op got %b want 00", OpCode); end
    checks++; if (flags_out !== 6'b000000) begin errors++; $display("FAIL reset_flags got %b want 000000", flags_out); end
    checks++; if (done !== 1'b0 || display !== 8'h3C) begin errors++; $display("FAIL reset_disp got %h done %b want 3c done 0", display, done); end
    resetN = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_add();
    data_in = 8'h05; press(1'b1, 1'b0);
    checks++; if (state_code !== 3'd1 || A !== 8'h05) begin errors++; $display("FAIL add_a got st %0d A %h want 1 05", state_code, A); end
    data_in = 8'h03; press(1'b1, 1'b0);
    checks++; if (state_code !== 3'd2 || B !== 8'h03) begin errors++; $display("FAIL add_b got st %0d B %h want 2 03", state_code, B); end
    op_in = 2'b10; #1;
    checks++; if (display !== 8'h02) begin errors++; $display("FAIL add_op_disp got %h want 02", display); end
    op_in = 2'b00; tb_flags = 6'b000001; enter = 1'b1;
    tick();
    checks++; if (state_code !== 3'd3 || done !== 1'b0) begin errors++; $display("FAIL add_exec got st %0d done %b want 3 0", state_code, done); end
    checks++; if (display !== 8'h00) begin errors++; $display("FAIL add_exec_disp got %h want 00", display); end
    enter = 1'b0;
    tick();
    checks++; if (state_code !== 3'd4 || done !== 1'b1) begin errors++; $display("FAIL add_latency got st %0d done %b want 4 1", state_code, done); end
    checks++; if (display !== 8'h08 || flags_out !== 6'b000001) begin errors++; $display("FAIL add_result got %h %b want 08 000001", display, flags_out); end
    tb_flags = 6'b111111; data_in = 8'hEE;
    tick();
    checks++; if (display !== 8'h08 || flags_out !== 6'b000001) begin errors++; $display("FAIL add_hold got %h %b want 08 000001", display, flags_out); end
    press(1'b0, 1'b1);
    checks++; if (state_code !== 3'd0 || A !== 8'h05 || B !== 8'h03) begin errors++; $display("FAIL show_undo got st %0d A %h B %h want 0 05 03", state_code, A, B); end
  endtask

  task automatic test_sub_overflow();
    tb_flags = 6'b100000; op_in = 2'b01;
    data_in = 8'h80; press(1'b1, 1'b0);
    data_in = 8'h01; press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++; if (state_code !== 3'd4 || OpCode !== 2'b01) begin errors++; $display("FAIL sub_state got st %0d op %b want 4 01", state_code, OpCode); end
    checks++; if (display !== 8'h7F || flags_out !== 6'b100000) begin errors++; $display("FAIL sub_result got %h %b want 7f 100000", display, flags_out); end
  endtask

  task automatic test_chain();
    data_in = 8'h55; tb_flags = 6'b011010;
    press(1'b1, 1'b0);
    checks++; if (state_code !== 3'd1 || A !== 8'h7F) begin errors++; $display("FAIL chain_a got st %0d A %h want 1 7f", state_code, A); end
    checks++; if (B !== 8'h01 || OpCode !== 2'b01 || flags_out !== 6'b100000) begin errors++; $display("FAIL chain_hold got B %h op %b fl %b want 01 01 100000", B, OpCode, flags_out); end
    checks++; if (display !== 8'h55) begin errors++; $display("FAIL chain_disp got %h want 55", display); end
    data_in = 8'h81; press(1'b1, 1'b0);
    op_in = 2'b00; press(1'b1, 1'b0);
    checks++; if (display !== 8'h00 || flags_out !== 6'b011010 || done !== 1'b1) begin errors++; $display("FAIL chain_result got %h %b done %b want 00 011010 1", display, flags_out, done); end
  endtask

  task automatic test_undo();
    press(1'b0, 1'b1);
    checks++; if (state_code !== 3'd0) begin errors++; $display("FAIL undo_show got %0d want 0", state_code); end
    press(1'b0, 1'b1);
    checks++; if (state_code !== 3'd0) begin errors++; $display("FAIL undo_wait_a got %0d want 0", state_code); end
    data_in = 8'h11; press(1'b1, 1'b0);
    data_in = 8'h22; press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++; if (state_code !== 3'd1 || B !== 8'h22) begin errors++; $display("FAIL undo_wait_op got st %0d B %h want 1 22", state_code, B); end
    data_in = 8'h33; press(1'b1, 1'b1);
    checks++; if (state_code !== 3'd2 || B !== 8'h33) begin errors++; $display("FAIL enter_priority got st %0d B %h want 2 33", state_code, B); end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    checks++; if (state_code !== 3'd0 || A !== 8'h11) begin errors++; $display("FAIL undo_back got st %0d A %h want 0 11", state_code, A); end
  endtask

  task automatic test_held();
    data_in = 8'h44; enter = 1'b1;
    tick();
    data_in = 8'h99;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (state_code !== 3'd1 || A !== 8'h44 || B !== 8'h33) begin errors++; $display("FAIL held_enter got st %0d A %h B %h want 1 44 33", state_code, A, B); end
    enter = 1'b0; tick();
    press(1'b0, 1'b1);
  endtask

  task automatic test_reset_exec();
    tb_flags = 6'b000011; op_in = 2'b00;
    data_in = 8'h10; press(1'b1, 1'b0);
    data_in = 8'h20; press(1'b1, 1'b0);
    enter = 1'b1;
    tick();
    checks++; if (state_code !== 3'd3) begin errors++; $display("FAIL rexec_pre got %0d want 3", state_code); end
    enter = 1'b0; resetN = 1'b0;
    tick();
    checks++; if (state_code !== 3'd0 || flags_out !== 6'b000000 || done !== 1'b0) begin errors++; $display("FAIL rexec_abort got st %0d fl %b done %b want 0 000000 0", state_code, flags_out, done); end
    checks++; if (A !== 8'h00 || B !== 8'h00 || OpCode !== 2'b00) begin errors++; $display("FAIL rexec_regs got %h %h %b want 00 00 00", A, B, OpCode); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_held_through_reset();
    resetN = 1'b0; enter = 1'b1; data_in = 8'h66;
    tick(); tick();
    resetN = 1'b1;
    tick(); tick(); tick();
    checks++; if (state_code !== 3'd0 || A !== 8'h00) begin errors++; $display("FAIL held_reset got st %0d A %h want 0 00", state_code, A); end
    enter = 1'b0; tick();
    enter = 1'b1; tick();
    checks++; if (state_code !== 3'd1 || A !== 8'h66) begin errors++; $display("FAIL held_release got st %0d A %h want 1 66", state_code, A); end
    enter = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_overflow();
    test_chain();
    test_undo();
    test_held();
    test_reset_exec();
    test_held_through_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
